reg_e_to_m: RTL and testbench
=============================

Name: reg_e_to_m

Overview:
- Execute-to-Memory pipeline register; sits directly downstream of the D-to-E register and the ALU.
- Captures the E-stage instruction, PCs, ALU result and store data on each enabled clock edge.
- Resolves the architectural write destination (rd / rt / $31).
- Ages the T_new hazard counter by one stage, so the hazard unit and forwarding muxes see M-stage timing directly.

Parameters:
- T_NONE, 5'h1F, T_new code meaning "no register write" (the -1 encoding used by upstream stages).

Ports:
- clk  input  1  pipeline clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- en  input  1  load enable; 0 = hold (M-stage stall)
- flush  input  1  synchronous bubble insert
- Instr_in  input  32  E-stage instruction
- PC_plus_4_in  input  32  E-stage PC+4
- PC_plus_8_in  input  32  E-stage PC+8 (link value)
- alu_result  input  32  ALU output / effective address
- rt_data  input  32  forwarded rt value (store data)
- T_new_in  input  5  E-stage T_new
- Instruction  output  32  registered instruction
- PC_plus_4  output  32  registered PC+4
- PC_plus_8  output  32  registered PC+8
- alu_out  output  32  registered ALU result
- store_data  output  32  registered store data
- write_reg  output  5  destination GPR; 0 when there is no write
- T_new  output  5  M-stage T_new
- byte_en  output  4  data-memory byte enables

Behaviour:
- Reset (async, any time):
  - all outputs 0, including T_new = 0 and write_reg = 0.
  - An in-flight instruction is discarded. There is no partial update.
- Priority at the rising clk edge: reset > flush > en > hold.
- flush = 1:
  - Loads a bubble: all 32-bit outputs 0, write_reg = 0, T_new = T_NONE, byte_en = 0.
  - Flush overrides en = 0.
- en = 1, flush = 0: load every field. Latency is exactly 1 cycle from input to output.
- en = 0, flush = 0: every output holds its value, T_new included. T_new is not aged while stalled.
- write_reg decode (from Instr_in):
  - R-type ALU ops and jalr: Instr_in[15:11].
  - I-type ALU ops (ori, xori, andi, slti, sltiu, addi, addiu, lui) and loads (lw, lb, lbu, lh, lhu): Instr_in[20:16].
  - jal: 5'd31.
  - Branches, stores, j, jr, nop, unknown opcodes: 0.
- T_new ageing on load:
  - T_new_in == T_NONE: T_NONE.
  - T_new_in == 0: 0 (saturate, no wrap to 31).
  - Otherwise: T_new_in - 1.
  - Override: if the decoded write_reg == 0, T_new = T_NONE. A write to $0 never creates a hazard.
- byte_en (without optional feature):
  - 4'b1111 for sw, sh, sb; 0 otherwise.
- Loads: byte_en = 0; load extension is done downstream.
- Unknown opcode: treated as a no-write, no-store bubble (write_reg = 0, T_new = T_NONE, byte_en = 0). Data fields are still captured.

Optional Feature:
- Macro: EM_BYTE_LANE_EN.
- Defined: byte_en is lane-accurate from alu_result[1:0].
  - sw: 4'b1111.
  - sh: addr[1] ? 4'b1100 : 4'b0011.
  - sb: 4'b0001 << addr[1:0].
  - store_data is replicated across lanes: sb uses {4{rt[7:0]}}, sh uses {2{rt[15:0]}}.
- Not defined: byte_en follows the base rule above and store_data = rt_data unmodified.

Decomposition:
- Shared package (mips_defs):
  - opcode and funct localparams for all supported instructions.
  - T_NONE.
  - the 5'd31 link-register constant.
- Sub-module em_dest_decode: purely combinational.
  - Inputs: Instr_in.
  - Outputs: write_reg and a store-kind code (none / byte / half / word).
  - The hazard unit reuses it.
- The top holds the registers, ageing logic and byte-lane logic.

Test Plan:
- addu $3,$1,$2 (0x00221821), T_new_in = 1, en = 1 -> next cycle write_reg = 3, T_new = 0, byte_en = 0.
- lw $5,4($0) (0x8C050004), T_new_in = 2 -> write_reg = 5, T_new = 1. Hold en = 0 for 3 cycles -> T_new stays 1 and alu_out is unchanged.
- jal (0x0C000010), T_new_in = 0 -> write_reg = 31, T_new = 0 (saturated), PC_plus_8 captured, e.g. 0x00003008.
- ori $0,$0,1 (0x34000001), T_new_in = 1 -> write_reg = 0, T_new = 5'h1F.
- sb with alu_result = 0x...2, rt_data = 0x000000AB:
  - EM_BYTE_LANE_EN defined -> byte_en = 4'b0100, store_data = 0xABABABAB.
  - Not defined -> byte_en = 4'b1111, store_data = 0x000000AB.
- flush = 1 with en = 0 -> bubble (T_new = 1F, Instruction = 0). Then assert reset mid-cycle (no clk edge) -> all outputs 0 immediately.

Source files
------------

// File: rtl/mips_defs.sv
// ============================================================================
//  Module : mips_defs (package)
//  Brief  : Shared opcode/funct codes, hazard constants and store-kind type
//           for the MIPS pipeline registers and hazard unit.
//  Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mips_defs;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_BLEZ  = 6'h06;
  localparam logic [5:0] OP_BGTZ  = 6'h07;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LH    = 6'h21;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_LBU   = 6'h24;
  localparam logic [5:0] OP_LHU   = 6'h25;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SH    = 6'h29;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_JALR = 6'h09;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // T_new value meaning "this instruction writes no register"
  localparam logic [4:0] T_NONE = 5'h1F;
  localparam logic [4:0] REG_RA = 5'd31;

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_BYTE = 2'd1,
    ST_HALF = 2'd2,
    ST_WORD = 2'd3
  } store_kind_t;

endpackage

`default_nettype wire

// File: rtl/em_dest_decode.sv
// ============================================================================
//  Module : em_dest_decode
//  Brief  : Combinational decode of the architectural write destination and
//           store width of an instruction; shared with the hazard unit.
//  Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module em_dest_decode
  import mips_defs::*;
(
  input  logic [31:0] Instr_in,
  output logic [4:0]  write_reg,
  output logic [1:0]  store_kind
);

  logic [5:0] w_op;
  logic [5:0] w_funct;

  assign w_op    = Instr_in[31:26];
  assign w_funct = Instr_in[5:0];

  always_comb begin
    write_reg  = 5'd0;
    store_kind = ST_NONE;
    case (w_op)
      OP_RTYPE: begin
        case (w_funct)
          FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_JALR,
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR,
          FN_NOR, FN_SLT, FN_SLTU: write_reg = Instr_in[15:11];
          default:                 write_reg = 5'd0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI,
      OP_LUI, OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:
        write_reg = Instr_in[20:16];
      OP_JAL: write_reg = REG_RA;
      OP_SB:  store_kind = ST_BYTE;
      OP_SH:  store_kind = ST_HALF;
      OP_SW:  store_kind = ST_WORD;
      default: begin
        write_reg  = 5'd0;
        store_kind = ST_NONE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/reg_e_to_m.sv
// ============================================================================
//  Module : reg_e_to_m
//  Brief  : Execute-to-Memory pipeline register with destination decode,
//           T_new ageing and data-memory byte enables.
//           Optional macro EM_BYTE_LANE_EN: lane-accurate byte enables and
//           replicated store data for sb/sh.
//  Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_e_to_m
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        flush,
  input  logic [31:0] Instr_in,
  input  logic [31:0] PC_plus_4_in,
  input  logic [31:0] PC_plus_8_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] rt_data,
  input  logic [4:0]  T_new_in,
  output logic [31:0] Instruction,
  output logic [31:0] PC_plus_4,
  output logic [31:0] PC_plus_8,
  output logic [31:0] alu_out,
  output logic [31:0] store_data,
  output logic [4:0]  write_reg,
  output logic [4:0]  T_new,
  output logic [3:0]  byte_en
);

  logic [4:0]  w_write_reg;
  logic [1:0]  w_store_kind;
  logic [4:0]  w_t_new;
  logic [3:0]  w_byte_en;
  logic [31:0] w_store_data;

  logic [31:0] r_instr;
  logic [31:0] r_pc4;
  logic [31:0] r_pc8;
  logic [31:0] r_alu;
  logic [31:0] r_store_data;
  logic [4:0]  r_write_reg;
  logic [4:0]  r_t_new;
  logic [3:0]  r_byte_en;

  em_dest_decode u_dest_decode (
    .Instr_in   (Instr_in),
    .write_reg  (w_write_reg),
    .store_kind (w_store_kind)
  );

  // A $0 destination never produces a hazard, whatever the E stage claimed.
  always_comb begin
    w_t_new = T_NONE;
    if (w_write_reg == 5'd0 || T_new_in == T_NONE) begin
      w_t_new = T_NONE;
    end else if (T_new_in == 5'd0) begin
      w_t_new = 5'd0;
    end else begin
      w_t_new = T_new_in - 5'd1;
    end
  end

  always_comb begin
    w_byte_en    = 4'b0000;
    w_store_data = rt_data;
`ifdef EM_BYTE_LANE_EN
    case (w_store_kind)
      ST_BYTE: begin
        w_byte_en    = 4'b0001 << alu_result[1:0];
        w_store_data = {4{rt_data[7:0]}};
      end
      ST_HALF: begin
        w_byte_en    = alu_result[1] ? 4'b1100 : 4'b0011;
        w_store_data = {2{rt_data[15:0]}};
      end
      ST_WORD: w_byte_en = 4'b1111;
      default: w_byte_en = 4'b0000;
    endcase
`else
    if (w_store_kind != ST_NONE) begin
      w_byte_en = 4'b1111;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_instr      <= 32'd0;
      r_pc4        <= 32'd0;
      r_pc8        <= 32'd0;
      r_alu        <= 32'd0;
      r_store_data <= 32'd0;
      r_write_reg  <= 5'd0;
      r_t_new      <= 5'd0;
      r_byte_en    <= 4'd0;
    end else if (flush) begin
      r_instr      <= 32'd0;
      r_pc4        <= 32'd0;
      r_pc8        <= 32'd0;
      r_alu        <= 32'd0;
      r_store_data <= 32'd0;
      r_write_reg  <= 5'd0;
      r_t_new      <= T_NONE;
      r_byte_en    <= 4'd0;
    end else if (en) begin
      r_instr      <= Instr_in;
      r_pc4        <= PC_plus_4_in;
      r_pc8        <= PC_plus_8_in;
      r_alu        <= alu_result;
      r_store_data <= w_store_data;
      r_write_reg  <= w_write_reg;
      r_t_new      <= w_t_new;
      r_byte_en    <= w_byte_en;
    end
  end

  assign Instruction = r_instr;
  assign PC_plus_4   = r_pc4;
  assign PC_plus_8   = r_pc8;
  assign alu_out     = r_alu;
  assign store_data  = r_store_data;
  assign write_reg   = r_write_reg;
  assign T_new       = r_t_new;
  assign byte_en     = r_byte_en;

endmodule

`default_nettype wire

// File: tb/tb_reg_e_to_m.sv
// ============================================================================
//  Module : tb_reg_e_to_m
//  Brief  : Self-checking bench for reg_e_to_m (directed vectors + model).
//  Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_e_to_m;

  logic        clk;
  logic        reset;
  logic        en;
  logic        flush;
  logic [31:0] Instr_in;
  logic [31:0] PC_plus_4_in;
  logic [31:0] PC_plus_8_in;
  logic [31:0] alu_result;
  logic [31:0] rt_data;
  logic [4:0]  T_new_in;
  logic [31:0] Instruction;
  logic [31:0] PC_plus_4;
  logic [31:0] PC_plus_8;
  logic [31:0] alu_out;
  logic [31:0] store_data;
  logic [4:0]  write_reg;
  logic [4:0]  T_new;
  logic [3:0]  byte_en;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [31:0] pc8;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  wr;
    logic [4:0]  tn;
    logic [3:0]  be;
  } exp_t;

  exp_t exp_s;

  reg_e_to_m dut (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .flush        (flush),
    .Instr_in     (Instr_in),
    .PC_plus_4_in (PC_plus_4_in),
    .PC_plus_8_in (PC_plus_8_in),
    .alu_result   (alu_result),
    .rt_data      (rt_data),
    .T_new_in     (T_new_in),
    .Instruction  (Instruction),
    .PC_plus_4    (PC_plus_4),
    .PC_plus_8    (PC_plus_8),
    .alu_out      (alu_out),
    .store_data   (store_data),
    .write_reg    (write_reg),
    .T_new        (T_new),
    .byte_en      (byte_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference: what the M stage must hold after one load of the given inputs.
  function automatic exp_t model_next(input logic [31:0] ins, input logic [31:0] p4,
                                      input logic [31:0] p8, input logic [31:0] a,
                                      input logic [31:0] rt, input logic [4:0] tin);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    e.instr = ins;
    e.pc4   = p4;
    e.pc8   = p8;
    e.alu   = a;
    e.sd    = rt;
    e.be    = 4'b0000;
    if (op == 6'h00 && (fn inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h09,
                                   6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26,
                                   6'h27, 6'h2A, 6'h2B}))
      e.wr = ins[15:11];
    else if (op inside {[6'h08:6'h0F], 6'h20, 6'h21, 6'h23, 6'h24, 6'h25})
      e.wr = ins[20:16];
    else if (op == 6'h03)
      e.wr = 5'd31;
    else
      e.wr = 5'd0;
    if (e.wr == 5'd0 || tin == 5'h1F) e.tn = 5'h1F;
    else if (tin == 5'd0)             e.tn = 5'd0;
    else                              e.tn = tin - 5'd1;
`ifdef EM_BYTE_LANE_EN
    if (op == 6'h28) begin
      e.be = 4'b0001 << a[1:0];
      e.sd = {4{rt[7:0]}};
    end else if (op == 6'h29) begin
      e.be = a[1] ? 4'b1100 : 4'b0011;
      e.sd = {2{rt[15:0]}};
    end else if (op == 6'h2B) begin
      e.be = 4'b1111;
    end
`else
    if (op inside {6'h28, 6'h29, 6'h2B}) e.be = 4'b1111;
`endif
    return e;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_s = '0;
    end else if (flush) begin
      exp_s    = '0;
      exp_s.tn = 5'h1F;
    end else if (en) begin
      exp_s = model_next(Instr_in, PC_plus_4_in, PC_plus_8_in, alu_result, rt_data, T_new_in);
    end
  end

  always @(negedge clk) begin
    chk("m_instr", Instruction, exp_s.instr);
    chk("m_pc4",   PC_plus_4,   exp_s.pc4);
    chk("m_pc8",   PC_plus_8,   exp_s.pc8);
    chk("m_alu",   alu_out,     exp_s.alu);
    chk("m_sd",    store_data,  exp_s.sd);
    chk("m_wr",    {27'd0, write_reg}, {27'd0, exp_s.wr});
    chk("m_tnew",  {27'd0, T_new},     {27'd0, exp_s.tn});
    chk("m_be",    {28'd0, byte_en},   {28'd0, exp_s.be});
  end

  task automatic apply(input logic [31:0] ins, input logic [31:0] p4, input logic [31:0] p8,
                       input logic [31:0] a, input logic [31:0] rt, input logic [4:0] tin);
    Instr_in     = ins;
    PC_plus_4_in = p4;
    PC_plus_8_in = p8;
    alu_result   = a;
    rt_data      = rt;
    T_new_in     = tin;
    en           = 1'b1;
    flush        = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; flush = 1'b0;
    Instr_in = '0; PC_plus_4_in = '0; PC_plus_8_in = '0;
    alu_result = '0; rt_data = '0; T_new_in = '0;
    repeat (2) @(negedge clk);
    chk("rst_tnew", {27'd0, T_new}, 32'd0);
    chk("rst_wr", {27'd0, write_reg}, 32'd0);
    reset = 1'b0;

    // addu $3,$1,$2
    apply(32'h00221821, 32'h1004, 32'h1008, 32'h0000_0007, 32'h2, 5'd1);
    chk("addu_wr", {27'd0, write_reg}, 32'd3);
    chk("addu_tnew", {27'd0, T_new}, 32'd0);
    chk("addu_be", {28'd0, byte_en}, 32'd0);

    // lw $5,4($0), then stall three cycles with changing inputs
    apply(32'h8C050004, 32'h2004, 32'h2008, 32'h0000_0004, 32'h0, 5'd2);
    chk("lw_wr", {27'd0, write_reg}, 32'd5);
    chk("lw_tnew", {27'd0, T_new}, 32'd1);
    en = 1'b0;
    Instr_in = 32'h00221821; alu_result = 32'hDEAD_BEEF; T_new_in = 5'd3;
    repeat (3) begin
      @(posedge clk); #1;
      chk("hold_tnew", {27'd0, T_new}, 32'd1);
      chk("hold_alu", alu_out, 32'h0000_0004);
    end

    // jal with T_new_in = 0 saturates
    apply(32'h0C000010, 32'h3004, 32'h3008, 32'h0, 32'h0, 5'd0);
    chk("jal_wr", {27'd0, write_reg}, 32'd31);
    chk("jal_tnew", {27'd0, T_new}, 32'd0);
    chk("jal_pc8", PC_plus_8, 32'h0000_3008);

    // ori $0,$0,1: write to $0 never creates a hazard
    apply(32'h34000001, 32'h4004, 32'h4008, 32'h1, 32'h0, 5'd1);
    chk("ori0_wr", {27'd0, write_reg}, 32'd0);
    chk("ori0_tnew", {27'd0, T_new}, 32'h1F);

    // sb at address ...2
    apply(32'hA0220002, 32'h5004, 32'h5008, 32'h0000_1002, 32'h0000_00AB, 5'd1);
`ifdef EM_BYTE_LANE_EN
    chk("sb_be", {28'd0, byte_en}, 32'h4);
    chk("sb_sd", store_data, 32'hABAB_ABAB);
`else
    chk("sb_be", {28'd0, byte_en}, 32'hF);
    chk("sb_sd", store_data, 32'h0000_00AB);
`endif
    chk("sb_wr", {27'd0, write_reg}, 32'd0);

    // sh at address ...2, sw, jr, beq, jalr, unknown opcode, T_NONE input
    apply(32'hA4220002, 32'h6004, 32'h6008, 32'h0000_2002, 32'h1234_ABCD, 5'd2);
`ifdef EM_BYTE_LANE_EN
    chk("sh_be", {28'd0, byte_en}, 32'hC);
`else
    chk("sh_be", {28'd0, byte_en}, 32'hF);
`endif
    apply(32'hAC220008, 32'h7004, 32'h7008, 32'h0000_3009, 32'hCAFE_F00D, 5'd2);
    chk("sw_be", {28'd0, byte_en}, 32'hF);
    apply(32'h03E00008, 32'h8004, 32'h8008, 32'h0, 32'h0, 5'd1);
    chk("jr_wr", {27'd0, write_reg}, 32'd0);
    apply(32'h10220003, 32'h9004, 32'h9008, 32'h0, 32'h0, 5'd1);
    apply(32'h0020F809, 32'hA004, 32'hA008, 32'h0, 32'h0, 5'd3);
    chk("jalr_tnew", {27'd0, T_new}, 32'd2);
    apply(32'hFC221821, 32'hB004, 32'hB008, 32'h5555_AAAA, 32'h1, 5'd2);
    chk("unk_tnew", {27'd0, T_new}, 32'h1F);
    chk("unk_alu", alu_out, 32'h5555_AAAA);
    apply(32'h00221821, 32'hC004, 32'hC008, 32'h0, 32'h0, 5'h1F);
    chk("tnone_tnew", {27'd0, T_new}, 32'h1F);
    apply(32'h24E70005, 32'hD004, 32'hD008, 32'h0, 32'h0, 5'd2);

    // flush overrides en = 0
    en = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    chk("flush_tnew", {27'd0, T_new}, 32'h1F);
    chk("flush_instr", Instruction, 32'h0);
    flush = 1'b0;

    // reload then assert reset mid-cycle, no clock edge
    apply(32'h8C050004, 32'hE004, 32'hE008, 32'h0000_0044, 32'h0, 5'd2);
    #1 reset = 1'b1;
    #1;
    chk("arst_tnew", {27'd0, T_new}, 32'd0);
    chk("arst_instr", Instruction, 32'd0);
    chk("arst_alu", alu_out, 32'd0);
    chk("arst_pc8", PC_plus_8, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    apply(32'h34A50001, 32'hF004, 32'hF008, 32'h1, 32'h0, 5'd1);
    chk("post_wr", {27'd0, write_reg}, 32'd5);
    en = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
